// File: rtl/dm_rmw_ctrl.sv
// dm_rmw_ctrl: data-memory access controller between the MEM stage and a
// word-wide single-port synchronous SRAM without byte enables. Word accesses
// pass straight through; byte/half stores become a read-modify-write pair.

package dm_pkg;
    typedef logic [31:0] word_t;
    typedef logic [31:0] dm_addr_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } ls_type_e;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } ls_width_e;

    typedef struct packed {
        ls_type_e  ls_type;
        ls_width_e ls_width;
        logic      sign;
    } memop_struct;
endpackage

module dm_rmw_ctrl
    import dm_pkg::*;
#(
    parameter int WADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  memop_struct        req_memop,
    input  dm_addr_t           req_addr,
    input  word_t              req_wdata,
    output logic               req_stall,
    output logic               rsp_valid,
    output word_t              rsp_rdata,
    output logic               misalign,
    output logic               sram_ce,
    output logic               sram_we,
    output logic [WADDR_W-1:0] sram_addr,
    output word_t              sram_din,
    input  word_t              sram_dout
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               load_pend_q, load_pend_d;
    logic               misalign_q, misalign_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [1:0]         lane_q, lane_d;
    logic               half_q, half_d;
    logic [15:0]        wdata_q, wdata_d;

    logic               isLoad;
    logic               isStore;
    logic               isAligned;
    logic [WADDR_W-1:0] reqWordAddr;
    word_t              mergedWord;
    logic               unused_bits;

    assign isLoad      = req_valid && (req_memop.ls_type == MEM_LOAD);
    assign isStore     = req_valid && (req_memop.ls_type == MEM_STORE);
    assign reqWordAddr = req_addr[WADDR_W+1:2];

    // Sign and the bytes above the SRAM address range are consumed in WB or unused here.
    assign unused_bits = ^{req_memop.sign, req_addr[31:WADDR_W+2], req_wdata[31:16]};

    // Alignment rule: words need a 4-byte boundary, halves a 2-byte boundary.
    always_comb begin
        isAligned = 1'b1;
        case (req_memop.ls_width)
            LS_WORD: isAligned = (req_addr[1:0] == 2'b00);
            LS_HALF: isAligned = (req_addr[0] == 1'b0);
            default: isAligned = 1'b1;
        endcase
    end

    // Splice the latched store lane into the word read back during the first RMW cycle.
    always_comb begin
        mergedWord = sram_dout;
        if (half_q) begin
            if (lane_q[1]) mergedWord[31:16] = wdata_q;
            else           mergedWord[15:0]  = wdata_q;
        end else begin
            case (lane_q)
                2'd0:    mergedWord[7:0]   = wdata_q[7:0];
                2'd1:    mergedWord[15:8]  = wdata_q[7:0];
                2'd2:    mergedWord[23:16] = wdata_q[7:0];
                default: mergedWord[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Next-state and SRAM command decode; requests are ignored while the RMW write runs.
    always_comb begin
        state_d     = state_q;
        load_pend_d = 1'b0;
        misalign_d  = 1'b0;
        addr_d      = addr_q;
        lane_d      = lane_q;
        half_d      = half_q;
        wdata_d     = wdata_q;
        req_stall   = 1'b0;
        sram_ce     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_din    = '0;
        case (state_q)
            IDLE: begin
                if ((isLoad || isStore) && !isAligned) begin
                    misalign_d = 1'b1;
                end else if (isLoad) begin
                    sram_ce     = 1'b1;
                    sram_addr   = reqWordAddr;
                    load_pend_d = 1'b1;
                end else if (isStore && (req_memop.ls_width == LS_WORD)) begin
                    sram_ce   = 1'b1;
                    sram_we   = 1'b1;
                    sram_addr = reqWordAddr;
                    sram_din  = req_wdata;
                end else if (isStore) begin
                    sram_ce   = 1'b1;
                    sram_addr = reqWordAddr;
                    req_stall = 1'b1;
                    addr_d    = reqWordAddr;
                    lane_d    = req_addr[1:0];
                    half_d    = (req_memop.ls_width == LS_HALF);
                    wdata_d   = req_wdata[15:0];
                    state_d   = RMW_WR;
                end
            end
            RMW_WR: begin
                sram_ce   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = addr_q;
                sram_din  = mergedWord;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, response flags and RMW latches; reset drops any in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_pend_q <= 1'b0;
            misalign_q  <= 1'b0;
            addr_q      <= '0;
            lane_q      <= '0;
            half_q      <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            load_pend_q <= load_pend_d;
            misalign_q  <= misalign_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            half_q      <= half_d;
            wdata_q     <= wdata_d;
        end
    end

    assign rsp_valid = load_pend_q;
    assign rsp_rdata = load_pend_q ? sram_dout : '0;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// tb_dm_rmw_ctrl: per-cycle vector table driving dm_rmw_ctrl against a
// behavioural word-wide SRAM, plus a reset-during-write sequence.

module tb_dm_rmw_ctrl;
    import dm_pkg::*;

    typedef struct {
        logic        valid;
        ls_type_e    typ;
        ls_width_e   wid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        ce;
        logic        we;
        logic [9:0]  saddr;
        logic [31:0] din;
        logic        rv;
        logic [31:0] rdata;
        logic        mis;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    memop_struct req_memop;
    dm_addr_t    req_addr;
    word_t       req_wdata;
    logic        req_stall;
    logic        rsp_valid;
    word_t       rsp_rdata;
    logic        misalign;
    logic        sram_ce;
    logic        sram_we;
    logic [9:0]  sram_addr;
    word_t       sram_din;
    word_t       sram_dout;

    word_t       mem [0:1023];
    vec_t        vecs[$];
    int          checks;
    int          errors;

    dm_rmw_ctrl #(.WADDR_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_memop (req_memop),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_stall (req_stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .misalign  (misalign),
        .sram_ce   (sram_ce),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port SRAM: registered read data, write on ce&we.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout <= mem[sram_addr];
        end
    end

    task automatic addVec(input logic v, input ls_type_e t, input ls_width_e w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic st, input logic ce, input logic we,
                          input logic [9:0] sa, input logic [31:0] din,
                          input logic rv, input logic [31:0] rd, input logic mis);
        vec_t x;
        x.valid = v;  x.typ = t;    x.wid = w;    x.addr = a;   x.wdata = wd;
        x.stall = st; x.ce = ce;    x.we = we;    x.saddr = sa; x.din = din;
        x.rv = rv;    x.rdata = rd; x.mis = mis;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input logic v, input ls_type_e t, input ls_width_e w,
                                 input logic [31:0] a, input logic [31:0] wd);
        req_valid = v;
        req_memop = '{ls_type: t, ls_width: w, sign: 1'b0};
        req_addr  = a;
        req_wdata = wd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input string tag, input vec_t x);
        checkOutput({tag, ".stall"}, 32'(req_stall), 32'(x.stall));
        checkOutput({tag, ".ce"},    32'(sram_ce),   32'(x.ce));
        checkOutput({tag, ".we"},    32'(sram_we),   32'(x.we));
        checkOutput({tag, ".saddr"}, 32'(sram_addr), 32'(x.saddr));
        checkOutput({tag, ".din"},   sram_din,       x.din);
        checkOutput({tag, ".rv"},    32'(rsp_valid), 32'(x.rv));
        checkOutput({tag, ".rdata"}, rsp_rdata,      x.rdata);
        checkOutput({tag, ".mis"},   32'(misalign),  32'(x.mis));
    endtask

    // Main sequence: reset, cycle table, then reset dropped in the RMW write cycle.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, MEM_NONE, LS_WORD, 32'h0, 32'h0);

        // Each row is one cycle: inputs, then the outputs expected during that cycle.
        //     v     type       width    addr     wdata         stl  ce   we   saddr  din           rv   rdata         mis
        addVec(1'b1, MEM_STORE, LS_WORD, 32'h010, 32'hDEADBEEF, 1'b0,1'b1,1'b1,10'd4, 32'hDEADBEEF, 1'b0,32'h0,        1'b0); // 0
        addVec(1'b1, MEM_LOAD,  LS_WORD, 32'h010, 32'h0,        1'b0,1'b1,1'b0,10'd4, 32'h0,        1'b0,32'h0,        1'b0); // 1
        addVec(1'b1, MEM_STORE, LS_WORD, 32'h020, 32'h11223344, 1'b0,1'b1,1'b1,10'd8, 32'h11223344, 1'b1,32'hDEADBEEF, 1'b0); // 2
        addVec(1'b1, MEM_STORE, LS_BYTE, 32'h022, 32'h000000AA, 1'b1,1'b1,1'b0,10'd8, 32'h0,        1'b0,32'h0,        1'b0); // 3
        addVec(1'b1, MEM_STORE, LS_BYTE, 32'h022, 32'h000000AA, 1'b0,1'b1,1'b1,10'd8, 32'h11AA3344, 1'b0,32'h0,        1'b0); // 4
        addVec(1'b1, MEM_LOAD,  LS_WORD, 32'h020, 32'h0,        1'b0,1'b1,1'b0,10'd8, 32'h0,        1'b0,32'h0,        1'b0); // 5
        addVec(1'b1, MEM_STORE, LS_WORD, 32'h030, 32'h11223344, 1'b0,1'b1,1'b1,10'd12,32'h11223344, 1'b1,32'h11AA3344, 1'b0); // 6
        addVec(1'b1, MEM_STORE, LS_HALF, 32'h032, 32'h5555BEEF, 1'b1,1'b1,1'b0,10'd12,32'h0,        1'b0,32'h0,        1'b0); // 7
        addVec(1'b1, MEM_STORE, LS_HALF, 32'h032, 32'h5555BEEF, 1'b0,1'b1,1'b1,10'd12,32'hBEEF3344, 1'b0,32'h0,        1'b0); // 8
        addVec(1'b1, MEM_LOAD,  LS_WORD, 32'h030, 32'h0,        1'b0,1'b1,1'b0,10'd12,32'h0,        1'b0,32'h0,        1'b0); // 9
        addVec(1'b1, MEM_LOAD,  LS_WORD, 32'h005, 32'h0,        1'b0,1'b0,1'b0,10'd0, 32'h0,        1'b1,32'hBEEF3344, 1'b0); // 10
        addVec(1'b0, MEM_NONE,  LS_WORD, 32'h0,   32'h0,        1'b0,1'b0,1'b0,10'd0, 32'h0,        1'b0,32'h0,        1'b1); // 11
        addVec(1'b1, MEM_STORE, LS_HALF, 32'h031, 32'h00001234, 1'b0,1'b0,1'b0,10'd0, 32'h0,        1'b0,32'h0,        1'b0); // 12
        addVec(1'b0, MEM_NONE,  LS_WORD, 32'h0,   32'h0,        1'b0,1'b0,1'b0,10'd0, 32'h0,        1'b0,32'h0,        1'b1); // 13
        addVec(1'b1, MEM_LOAD,  LS_WORD, 32'h030, 32'h0,        1'b0,1'b1,1'b0,10'd12,32'h0,        1'b0,32'h0,        1'b0); // 14
        addVec(1'b1, MEM_STORE, LS_WORD, 32'h040, 32'hA5A5A5A5, 1'b0,1'b1,1'b1,10'd16,32'hA5A5A5A5, 1'b1,32'hBEEF3344, 1'b0); // 15
        addVec(1'b1, MEM_STORE, LS_BYTE, 32'h041, 32'h00000077, 1'b1,1'b1,1'b0,10'd16,32'h0,        1'b0,32'h0,        1'b0); // 16
        addVec(1'b1, MEM_STORE, LS_BYTE, 32'h041, 32'h00000077, 1'b0,1'b1,1'b1,10'd16,32'hA5A577A5, 1'b0,32'h0,        1'b0); // 17
        addVec(1'b1, MEM_LOAD,  LS_WORD, 32'h040, 32'h0,        1'b0,1'b1,1'b0,10'd16,32'h0,        1'b0,32'h0,        1'b0); // 18
        addVec(1'b1, MEM_STORE, LS_BYTE, 32'h043, 32'h0000003C, 1'b1,1'b1,1'b0,10'd16,32'h0,        1'b1,32'hA5A577A5, 1'b0); // 19
        addVec(1'b1, MEM_STORE, LS_BYTE, 32'h043, 32'h0000003C, 1'b0,1'b1,1'b1,10'd16,32'h3CA577A5, 1'b0,32'h0,        1'b0); // 20
        addVec(1'b1, MEM_LOAD,  LS_WORD, 32'h040, 32'h0,        1'b0,1'b1,1'b0,10'd16,32'h0,        1'b0,32'h0,        1'b0); // 21
        addVec(1'b1, MEM_NONE,  LS_WORD, 32'h050, 32'h12345678, 1'b0,1'b0,1'b0,10'd0, 32'h0,        1'b1,32'h3CA577A5, 1'b0); // 22
        addVec(1'b1, MEM_LOAD,  LS_BYTE, 32'h013, 32'h0,        1'b0,1'b1,1'b0,10'd4, 32'h0,        1'b0,32'h0,        1'b0); // 23
        addVec(1'b1, MEM_LOAD,  LS_HALF, 32'h012, 32'h0,        1'b0,1'b1,1'b0,10'd4, 32'h0,        1'b1,32'hDEADBEEF, 1'b0); // 24
        addVec(1'b0, MEM_NONE,  LS_WORD, 32'h0,   32'h0,        1'b0,1'b0,1'b0,10'd0, 32'h0,        1'b1,32'hDEADBEEF, 1'b0); // 25

        #12;
        checkOutput("rst.ce",    32'(sram_ce),   32'h0);
        checkOutput("rst.we",    32'(sram_we),   32'h0);
        checkOutput("rst.stall", 32'(req_stall), 32'h0);
        checkOutput("rst.rv",    32'(rsp_valid), 32'h0);
        checkOutput("rst.rdata", rsp_rdata,      32'h0);
        checkOutput("rst.mis",   32'(misalign),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].valid, vecs[i].typ, vecs[i].wid, vecs[i].addr, vecs[i].wdata);
            #2;
            checkVector($sformatf("v%0d", i), vecs[i]);
        end

        // Reset lands in the write cycle of a byte RMW on word 0x020 (holds 0x11AA3344).
        @(negedge clk);
        applyStimulus(1'b1, MEM_STORE, LS_BYTE, 32'h020, 32'h00000099);
        #2;
        checkOutput("rr.rd.stall", 32'(req_stall), 32'h1);
        checkOutput("rr.rd.we",    32'(sram_we),   32'h0);
        @(negedge clk);
        #2;
        checkOutput("rr.wr.we",    32'(sram_we),   32'h1);
        checkOutput("rr.wr.din",   sram_din,       32'h11AA3399);
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b0, MEM_NONE, LS_WORD, 32'h0, 32'h0);
        #1;
        checkOutput("rr.async.ce",    32'(sram_ce),   32'h0);
        checkOutput("rr.async.we",    32'(sram_we),   32'h0);
        checkOutput("rr.async.saddr", 32'(sram_addr), 32'h0);
        checkOutput("rr.async.din",   sram_din,       32'h0);
        checkOutput("rr.async.stall", 32'(req_stall), 32'h0);
        checkOutput("rr.async.rv",    32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, MEM_LOAD, LS_WORD, 32'h020, 32'h0);
        #2;
        checkOutput("rr.ld.ce",    32'(sram_ce),   32'h1);
        checkOutput("rr.ld.saddr", 32'(sram_addr), 32'd8);
        @(negedge clk);
        applyStimulus(1'b0, MEM_NONE, LS_WORD, 32'h0, 32'h0);
        #2;
        checkOutput("rr.ld.rv",    32'(rsp_valid), 32'h1);
        checkOutput("rr.ld.rdata", rsp_rdata,      32'h11AA3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_rmw_ctrl.md
# dm_rmw_ctrl

Data-memory access controller between the MEM stage and a single-port, word-wide synchronous SRAM with no byte enables. Word loads and stores go straight through in one cycle. Byte and half stores are sequenced as a two-cycle read-modify-write, and the controller stalls the pipeline for one cycle while it runs. Misaligned accesses are flagged and suppressed.

## Interface
Parameters:
- WADDR_W, default 10: SRAM word-address width; `sram_addr` carries byte-address bits [WADDR_W+1:2].

Ports:
- clk  in  1: clock; every register updates on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- req_valid  in  1: MEM stage presents an access this cycle.
- req_memop  in  memop_struct: access type, width and sign (`ls_type`, `ls_width`, `sign`).
- req_addr  in  dm_addr_t: byte address (MEM-stage ALU result).
- req_wdata  in  word_t: store data, right-aligned (byte in [7:0], half in [15:0]).
- req_stall  out  1: requester must hold every `req_*` input stable next cycle.
- rsp_valid  out  1: load data valid on `rsp_rdata`.
- rsp_rdata  out  word_t: raw SRAM word; lane selection and sign extension happen in WB.
- misalign  out  1: one-cycle pulse, previous request was misaligned.
- sram_ce  out  1: SRAM chip enable.
- sram_we  out  1: SRAM write enable.
- sram_addr  out  WADDR_W: SRAM word address.
- sram_din  out  word_t: SRAM write data.
- sram_dout  in  word_t: SRAM read data, valid the cycle after a read command.

## Operation
- A request is consumed on any cycle where `req_valid & !req_stall`. `ls_type==MEM_NONE` counts as no request.
- Alignment: WORD needs addr[1:0]==0; HALF needs addr[0]==0; BYTE is always aligned.
- Misaligned request:
  - No SRAM access and no stall.
  - `misalign` is registered high the next cycle.
  - `rsp_valid` stays 0.
- FSM states are IDLE and RMW_WR.
- IDLE, aligned load (any width):
  - Drive ce=1, we=0, addr=req_addr word address.
  - Set a registered `load_pend`, so `rsp_valid`=1 next cycle with `rsp_rdata=sram_dout`.
  - Stay in IDLE.
- IDLE, aligned WORD store:
  - Drive ce=1, we=1, din=req_wdata.
  - Stay in IDLE. `req_stall`=0.
- IDLE, aligned BYTE/HALF store:
  - Drive ce=1, we=0 (read of the target word) and assert `req_stall`=1.
  - Latch the word address, lane and data into internal registers.
  - Go to RMW_WR.
- RMW_WR:
  - Drive ce=1, we=1, addr=latched address, din=merged word.
  - `req_stall`=0, so the held request is consumed this cycle. `req_*` is ignored in this state.
  - Go to IDLE.
- Merge, BYTE: lane k=addr[1:0]; bits [8k+7:8k] of `sram_dout` are replaced by wdata[7:0]. All other bits keep the read value.
- Merge, HALF: lane h=addr[1]; bits [16h+15:16h] are replaced by wdata[15:0].
- The RMW read never produces `rsp_valid`.
- `req_stall` is combinational from the IDLE state and the request decode. It is high only in the IDLE cycle that starts an RMW.
- SRAM outputs are combinational in IDLE and driven from registers in RMW_WR. With no access, ce=we=0 and addr/din hold 0.
- A request in the cycle after RMW_WR is handled normally from IDLE, so back-to-back sub-word stores cost 2 cycles each.

## Timing
- Load latency: command in cycle N, data in cycle N+1. Back-to-back loads sustain one per cycle.
- Word store: 1 cycle, 0 stall.
- Sub-word store: 2 cycles, 1 stall cycle (read in N, write in N+1).
- Misalign pulse: at N+1, width exactly 1 cycle.
- Reset values, asynchronous: state=IDLE, `load_pend`=0, `misalign`=0, `rsp_valid`=0, `rsp_rdata`=0 while no load is pending, latched registers=0, sram_ce/we=0.
- Reset asserted during RMW_WR: the write is dropped (ce=we=0 immediately) and memory keeps its old word.
- After reset deassertion, the first rising edge may accept a request.

## Test plan
- Word store then load: store 0xDEADBEEF @0x010, then load @0x010.
  - Store: 1 cycle, no stall.
  - Load: `rsp_valid` the next cycle with 0xDEADBEEF.
- Byte RMW: word @0x020 = 0x11223344; byte store 0xAA @0x022.
  - `req_stall` high exactly 1 cycle.
  - SRAM read then write of 0x11AA3344; a subsequent load returns 0x11AA3344.
- Half RMW, upper lane: word @0x030 = 0x11223344; half store 0xBEEF @0x032.
  - Memory becomes 0xBEEF3344.
- Misaligned: word load @0x005 and half store @0x031.
  - Each gives a 1-cycle `misalign` pulse, with no sram_ce and no stall.
  - Memory is unchanged.
- Back-to-back: byte store @0x040, then word load @0x040 presented on the consume cycle, then a byte store again.
  - Expected sequence: read, write, read, read, write.
  - The load returns the merged word.
- Reset during RMW_WR: drop rst_n in the write cycle.
  - Outputs go to 0 asynchronously and memory keeps its prior value.
  - After release, a load returns that prior value.
